// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash read engine: one READ (0x03) command per 32-bit word fetch.
// Returns the four bytes at the word address as a little-endian word.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        sck_o,
    output logic        sdo_o,
    input  logic        sdi_i,
    output logic        cs_no
);

    localparam int DIV_W = 8;
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic [31:0]        tx_q, tx_d;
    logic [31:0]        rx_q, rx_d;
    logic [5:0]         bit_q, bit_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               cs_n_q, cs_n_d;
    logic               sck_q, sck_d;
    logic               sdo_q, sdo_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               gnt;
    logic               div_end;
    logic [31:0]        tx_word;
    logic               addr_unused;

    assign addr_unused = ^addr_i[1:0];

    assign gnt     = req_i & ready_q & (state_q == IDLE);
    assign div_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign tx_word = {8'h03, addr_i[23:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b1;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        div_d    = div_q;
        gap_d    = gap_q;
        cs_n_d   = cs_n_q;
        sck_d    = sck_q;
        sdo_d    = sdo_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (gnt) begin
                    tx_d    = tx_word;
                    bit_d   = 6'd0;
                    div_d   = '0;
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    sdo_d   = tx_word[31];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        // Second half of the frame carries flash data.
                        if (bit_q[5]) begin
                            rx_d = {rx_q[30:0], sdi_i};
                        end
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 6'd63) begin
                            cs_n_d   = 1'b1;
                            sdo_d    = 1'b0;
                            rvalid_d = 1'b1;
                            rdata_d  = {rx_q[7:0], rx_q[15:8],
                                        rx_q[23:16], rx_q[31:24]};
                            gap_d    = '0;
                            state_d  = GAP;
                        end else begin
                            bit_d = bit_q + 6'd1;
                            tx_d  = {tx_q[30:0], 1'b0};
                            sdo_d = (bit_q < 6'd31) ? tx_q[30] : 1'b0;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            gap_q    <= '0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            cs_n_q   <= cs_n_d;
            sck_q    <= sck_d;
            sdo_q    <= sdo_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign sck_o    = sck_q;
    assign sdo_o    = sdo_q;
    assign cs_no    = cs_n_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and 1) with SPI flash models.
// Expected words go into per-instance queues and are popped on rvalid_o.
module tb_spi_flash_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [23:0] addr0 = '0, addr1 = '0;
    logic        gnt0, gnt1, rv0, rv1;
    logic        sck0, sck1, sdo0, sdo1, cs0, cs1;
    logic        sdi0 = 1'b0, sdi1 = 1'b0;
    logic [31:0] rd0, rd1;

    spi_flash_reader #(.CLK_DIV(2), .CS_GAP(2)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .addr_i(addr0),
        .gnt_o(gnt0), .rvalid_o(rv0), .rdata_o(rd0), .sck_o(sck0),
        .sdo_o(sdo0), .sdi_i(sdi0), .cs_no(cs0)
    );

    spi_flash_reader #(.CLK_DIV(1), .CS_GAP(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .addr_i(addr1),
        .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .sck_o(sck1),
        .sdo_o(sdo1), .sdi_i(sdi1), .cs_no(cs1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] fw0 = '0, fw1 = '0;
    logic [31:0] cmd0 = '0, cmd1 = '0;
    int edges0 = 0, edges1 = 0;
    int last0 = 0, last1 = 0;
    int badper0 = 0, badper1 = 0;
    int badg0 = 0, badg1 = 0;
    int nrv0 = 0, nrv1 = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] st0, st1;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign st0 = bswap(fw0);
    assign st1 = bswap(fw1);

    // Flash models: capture command on SCK rise, drive data on SCK fall.
    always @(posedge sck0 or negedge cs0) begin
        if (!sck0) begin
            edges0 <= 0;
            cmd0   <= '0;
        end else if (!cs0) begin
            if (edges0 < 32) cmd0 <= {cmd0[30:0], sdo0};
            if (edges0 > 0 && (cyc - last0) != 4) badper0 <= badper0 + 1;
            last0  <= cyc;
            edges0 <= edges0 + 1;
        end
    end

    always @(negedge sck0)
        if (!cs0 && edges0 >= 32 && edges0 < 64) sdi0 <= st0[5'(63 - edges0)];

    always @(posedge sck1 or negedge cs1) begin
        if (!sck1) begin
            edges1 <= 0;
            cmd1   <= '0;
        end else if (!cs1) begin
            if (edges1 < 32) cmd1 <= {cmd1[30:0], sdo1};
            if (edges1 > 0 && (cyc - last1) != 2) badper1 <= badper1 + 1;
            last1  <= cyc;
            edges1 <= edges1 + 1;
        end
    end

    always @(negedge sck1)
        if (!cs1 && edges1 >= 32 && edges1 < 64) sdi1 <= st1[5'(63 - edges1)];

    always @(negedge clk) begin
        if (gnt0 && !cs0) badg0 <= badg0 + 1;
        if (gnt1 && !cs1) badg1 <= badg1 + 1;
        if (rv0) nrv0 <= nrv0 + 1;
        if (rv1) nrv1 <= nrv1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_read(input int sel, input logic [23:0] a,
                              input logic [31:0] w, input bit hold,
                              output int g);
        g = -1;
        @(posedge clk); #1;
        if (sel == 0) begin
            addr0 = a; fw0 = w; req0 = 1'b1; q0.push_back(w);
        end else begin
            addr1 = a; fw1 = w; req1 = 1'b1; q1.push_back(w);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((sel == 0) ? gnt0 : gnt1) begin
                g = cyc;
                break;
            end
        end
        chk("grant_seen", 32'(g >= 0), 32'd1);
        if (!hold) begin
            @(posedge clk); #1;
            if (sel == 0) req0 = 1'b0;
            else req1 = 1'b0;
        end
    endtask

    task automatic wait_rv(input int sel, input int g, input int div,
                           input logic [23:0] a, output int r);
        logic [31:0] exp;
        r = -1;
        for (int i = 0; i < 400 * div; i++) begin
            @(negedge clk);
            if ((sel == 0) ? rv0 : rv1) begin
                r = cyc;
                break;
            end
        end
        chk("rvalid_seen", 32'(r >= 0), 32'd1);
        chk("latency", 32'(r - g), 32'(1 + 128 * div));
        if (sel == 0) begin
            exp = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
            chk("rdata", rd0, exp);
            chk("cs_at_rvalid", 32'(cs0), 32'd1);
            chk("sck_edges", 32'(edges0), 32'd64);
            chk("cmd", cmd0, {8'h03, a[23:2], 2'b00});
        end else begin
            exp = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
            chk("rdata", rd1, exp);
            chk("cs_at_rvalid", 32'(cs1), 32'd1);
            chk("sck_edges", 32'(edges1), 32'd64);
            chk("cmd", cmd1, {8'h03, a[23:2], 2'b00});
        end
    endtask

    initial begin
        int g, r, g2, c0, cshi, n;
        bit found;

        // Reset with a request already pending.
        #1 rst_n = 1'b0;
        addr0 = 24'h200000;
        req0  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("gnt_in_reset", 32'(gnt0), 32'd0);
        end
        chk("rst_cs", 32'(cs0), 32'd1);
        chk("rst_sck", 32'(sck0), 32'd0);
        chk("rst_sdo", 32'(sdo0), 32'd0);
        chk("rst_rvalid", 32'(rv0), 32'd0);
        chk("rst_rdata", rd0, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("gnt_first_cycle", 32'(gnt0), 32'd0);

        // Boot vector read.
        start_read(0, 24'h200000, 32'h0000_0013, 1'b0, g);
        chk("grant_after_reset", 32'(g), 32'(c0 + 1));
        wait_rv(0, g, 2, 24'h200000, r);

        // Unaligned address.
        start_read(0, 24'h200006, 32'hDEAD_BEEF, 1'b0, g);
        wait_rv(0, g, 2, 24'h200006, r);

        // Back-to-back with req held high.
        start_read(0, 24'h001230, 32'h1122_3344, 1'b1, g);
        wait_rv(0, g, 2, 24'h001230, r);
        fw0 = 32'h5566_7788;
        q0.push_back(fw0);
        cshi = cs0 ? 1 : 0;
        g2 = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cs0) cshi++;
            if (gnt0) begin
                g2 = cyc;
                break;
            end
        end
        chk("b2b_gap", 32'(g2 - r), 32'd2);
        chk("b2b_cs_high", 32'(cshi), 32'd3);
        @(posedge clk); #1 req0 = 1'b0;
        wait_rv(0, g2, 2, 24'h001230, r);

        // Reset during bit 20.
        start_read(0, 24'h000100, 32'hCAFE_F00D, 1'b0, g);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (edges0 == 21) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_bit20", 32'(found), 32'd1);
        n = nrv0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_cs", 32'(cs0), 32'd1);
        chk("abort_sck", 32'(sck0), 32'd0);
        chk("abort_rdata", rd0, 32'd0);
        q0.delete();
        addr0 = 24'h0ABCD4;
        req0  = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("abort_gnt_first", 32'(gnt0), 32'd0);
        chk("abort_no_rvalid", 32'(nrv0), 32'(n));
        start_read(0, 24'h0ABCD4, 32'h0BAD_F00D, 1'b0, g);
        chk("abort_grant_cycle", 32'(g), 32'(c0 + 1));
        wait_rv(0, g, 2, 24'h0ABCD4, r);

        // Minimum divider.
        start_read(1, 24'h00ABC8, 32'h89AB_CDEF, 1'b0, g);
        wait_rv(1, g, 1, 24'h00ABC8, r);
        start_read(1, 24'h7FFFFD, 32'h0F1E_2D3C, 1'b0, g);
        wait_rv(1, g, 1, 24'h7FFFFC, r);

        repeat (5) @(negedge clk);
        chk("gnt_in_shift_0", 32'(badg0), 32'd0);
        chk("gnt_in_shift_1", 32'(badg1), 32'd0);
        chk("sck_period_div2", 32'(badper0), 32'd0);
        chk("sck_period_div1", 32'(badper1), 32'd0);
        chk("queues_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

SPI flash read engine feeding the SoC instruction and data fetch path from the board's QSPI-capable flash, operated in plain single-bit SPI mode 0. Accepts word read requests on a req/gnt/rvalid handshake, issues a standard READ (0x03) command with a 24-bit address, and returns one 32-bit little-endian word per transaction. It drives the flash pins `sck`, `sdo` and `cs` that leave the SoC. The SoC's boot vector lies in flash at 0x200000, so this block serves the first fetch after reset.

## Interface
- `CLK_DIV`, 2: clk_i cycles per SCK half-period; legal range 1..255.
- `CS_GAP`, 2: minimum idle cycles after `rvalid_o` before the next grant; legal range 1..15.
- `clk_i` in 1: system clock; the only clock in the block.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_i` in 1: read request; held high until granted.
- `addr_i` in 24: byte address; bits [1:0] are ignored. Must be stable while `req_i` is high.
- `gnt_o` out 1: request accepted in this cycle.
- `rvalid_o` out 1: one-cycle pulse; `rdata_o` is valid.
- `rdata_o` out 32: read word; holds its value until the next `rvalid_o`.
- `sck_o` out 1: SPI clock, idle low.
- `sdo_o` out 1: MOSI.
- `sdi_i` in 1: MISO.
- `cs_no` out 1: flash chip select, active low.

## Operation
- **States:** IDLE, SHIFT, GAP.
- **Ready flag:** `ready_q` resets to 0 and is set on the first clock after reset is released.
- **Grant rule:** `gnt_o = req_i & ready_q & (state==IDLE)`. This is combinational and is never high outside IDLE.
- **Grant edge (IDLE→SHIFT):**
  - Latch the 32-bit TX shift word {8'h03, addr_i[23:2], 2'b00}.
  - Clear the bit counter (6 bits, 0..63) and the divider counter.
  - Set `cs_no`←0, `sck_o`←0, `sdo_o`←TX bit 31.
- **SHIFT, general:**
  - The divider counts CLK_DIV cycles per half-period.
  - `sdo_o` changes only while `sck_o` is low, and only at the end of a high phase.
- **SHIFT, end of a low phase:**
  - `sck_o`←1.
  - If the bit counter is ≥32, shift `sdi_i` into the RX register.
- **SHIFT, end of a high phase:**
  - `sck_o`←0 and the bit counter increments.
  - For bits 0..30, `sdo_o`←next TX bit (MSB first). For bits ≥31, `sdo_o`←0.
- **Completion:** at the end of the high phase of bit 63, in a single edge:
  - `sck_o`←0, `cs_no`←1, state→GAP, `rvalid_o`←1.
  - `rdata_o`←{B3,B2,B1,B0}, where B0 is the first byte received (the byte at the word address) and each byte is received MSB first.
- **GAP:** `rvalid_o` is high only in the first GAP cycle. The block stays in GAP for CS_GAP cycles, then goes to IDLE.
- **Pending requests:** a request held during SHIFT or GAP waits and is granted in the first IDLE cycle. No request is ever dropped.
- **Reset values:** `cs_no`=1, `sck_o`=0, `sdo_o`=0, `rvalid_o`=0, `rdata_o`=0, `gnt_o`=0, state=IDLE.
- **Reset mid-transfer:** the outputs take their reset values immediately (asynchronously). No `rvalid_o` is produced for the aborted read. The flash sees `cs_no` rise, which terminates the command.

## Timing
- **Grant cycle:** call the grant cycle G.
  - `cs_no` is low from G+1.
  - First SCK rising edge at the end of cycle G+CLK_DIV.
- **SCK waveform:** period 2·CLK_DIV clk cycles, 50% duty, exactly 64 rising edges per transaction.
- **Latency:** `rvalid_o` is high in cycle G+1+128·CLK_DIV. That is G+257 for CLK_DIV=2 and G+129 for CLK_DIV=1.
- **Chip-select deassertion:** `cs_no` is high from the `rvalid_o` cycle onward.
- **Back-to-back reads:** with `req_i` held high, the next `gnt_o` is in cycle rvalid+CS_GAP, so `cs_no` is high for CS_GAP+1 cycles between transactions.
- **Sampling:** `sdi_i` is sampled on the clk edge that raises `sck_o`. The flash drives data on the SCK falling edge, which gives CLK_DIV cycles of setup.
- **After reset release:** the earliest grant is in the second cycle after `rst_ni` rises.

## Test plan
- **Basic read:** CLK_DIV=2, `addr_i`=0x200000; the flash model returns 0x13,0x00,0x00,0x00.
  - Bits on `sdo_o` are 0x03,0x20,0x00,0x00.
  - `rdata_o`=0x00000013 with `rvalid_o` at G+257.
  - Exactly 64 SCK rising edges occur.
- **Unaligned address:** `addr_i`=0x200006.
  - The address bits sent are 0x200004.
  - Model bytes 0xEF,0xBE,0xAD,0xDE give `rdata_o`=0xDEADBEEF.
- **Back-to-back:** `req_i` held high for two reads with CS_GAP=2.
  - The second `gnt_o` arrives exactly 2 cycles after the first `rvalid_o`.
  - `cs_no` is high for 3 cycles in between.
  - `gnt_o` is never high during SHIFT.
- **Reset mid-transfer:** assert `rst_ni` low during bit 20.
  - `cs_no`=1, `sck_o`=0 and `rdata_o`=0 with no clock edge needed.
  - No `rvalid_o` occurs.
  - After release, `gnt_o` is 0 in the first cycle and a new read completes normally.
- **Minimum divider:** CLK_DIV=1.
  - The SCK period is 2 cycles.
  - `rvalid_o` is at G+129.
  - Data is correct with the model driving on the falling edge.
- **Reset-held request:** `req_i` is high while `rst_ni` is low.
  - `gnt_o` stays 0 while `rst_ni` is low.
  - The grant occurs in the second cycle after reset release.
